qmac_dot: RTL and testbench



---
 rtl/qmac_pkg.sv | 64 ++++++
 rtl/qmac_dot_qmult_sat.sv | 58 +++++
 rtl/qmac_dot.sv | 175 +++++++++++++++++
 tb/tb_qmac_dot.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qmac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qmac_pkg
//  Description : Shared types and helpers for the qmac_dot dot-product engine.
//                - FSM state encoding (ACCUM / DRAIN / HOLD)
//                - sat_to_n(): clamps a wide signed value to a given width and
//                  reports whether clamping happened
//                - width helpers for the adder tree and the accumulator
//  Revision    : 1.0 - initial release
// ============================================================================
package qmac_pkg;

    // Working width for saturation arithmetic; wide enough for any
    // accumulator or lane intermediate with N <= 64.
    localparam int c_SAT_W = 128;

    localparam logic [1:0] c_ST_ACCUM = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ST_ACCUM = c_ST_ACCUM,
        ST_DRAIN = c_ST_DRAIN,
        ST_HOLD  = c_ST_HOLD
    } qmac_state_e;

    typedef struct packed {
        logic               ovr;
        logic [c_SAT_W-1:0] val;
    } sat_res_t;

    // Adder-tree output width: lossless sum of LANES N-bit terms.
    function automatic int tree_width(input int n, input int lanes);
        return n + $clog2(lanes);
    endfunction

    // Accumulator width: tree width plus headroom.
    function automatic int acc_width(input int n, input int lanes, input int guard);
        return tree_width(n, lanes) + guard;
    endfunction

    // Clamp a signed value to a signed 'width'-bit range. The low 'width'
    // bits of .val hold the result; .ovr flags that clamping occurred.
    function automatic sat_res_t sat_to_n(input logic signed [c_SAT_W-1:0] value,
                                          input int                        width);
        logic signed [c_SAT_W-1:0] w_max;
        logic signed [c_SAT_W-1:0] w_min;
        sat_res_t                  w_res;
        w_max     = (c_SAT_W'(1) << (width - 1)) - c_SAT_W'(1);
        w_min     = ~w_max;
        w_res.ovr = 1'b0;
        w_res.val = value;
        if (value > w_max) begin
            w_res.val = w_max;
            w_res.ovr = 1'b1;
        end else if (value < w_min) begin
            w_res.val = w_min;
            w_res.ovr = 1'b1;
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qmac_dot_qmult_sat.sv
`default_nettype none
// ============================================================================
//  Module      : qmult_sat
//  Description : One multiply lane. Forms the full 2N-bit signed product,
//                optionally rounds half up, arithmetic-shifts right by Q and
//                clamps to N bits with an overflow flag. Purely combinational.
//  Config      : QMAC_ROUND_EN - add 2^(Q-1) before the shift (round half up)
//  Ports       : i_a, i_b  signed Q-format operands (N bits)
//                o_p       clamped Q-format product (N bits)
//                o_ovr     product did not fit N bits
//  Revision    : 1.0 - initial release
// ============================================================================
module qmult_sat
    import qmac_pkg::*;
#(
    parameter int N = 32,
    parameter int Q = 10
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_p,
    output logic         o_ovr
);

    logic signed [2*N-1:0]     w_a_ext;
    logic signed [2*N-1:0]     w_b_ext;
    logic signed [2*N-1:0]     w_prod;
    logic signed [2*N-1:0]     w_adj;
    logic signed [2*N-1:0]     w_shift;
    logic signed [c_SAT_W-1:0] w_wide;
    sat_res_t                  w_sat;
    logic                      w_unused_hi;

    // Operands widened first so the multiply is evaluated at full 2N width.
    assign w_a_ext = {{N{i_a[N-1]}}, i_a};
    assign w_b_ext = {{N{i_b[N-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

`ifdef QMAC_ROUND_EN
    localparam logic signed [2*N-1:0] c_HALF = (Q > 0) ? ((2*N)'(1) << (Q - 1)) : '0;
    // The product magnitude is at most 2^(2N-2), so adding the half-LSB
    // cannot wrap the 2N-bit signed range.
    assign w_adj = w_prod + c_HALF;
`else
    assign w_adj = w_prod;
`endif

    // Arithmetic shift: truncation toward minus infinity.
    assign w_shift = w_adj >>> Q;
    assign w_wide  = {{(c_SAT_W-2*N){w_shift[2*N-1]}}, w_shift};
    assign w_sat   = sat_to_n(w_wide, N);

    assign o_p         = w_sat.val[N-1:0];
    assign o_ovr       = w_sat.ovr;
    assign w_unused_hi = ^w_sat.val[c_SAT_W-1:N];

endmodule
`default_nettype wire

// File: rtl/qmac_dot.sv
`default_nettype none
// ============================================================================
//  Module      : qmac_dot
//  Description : Multi-lane signed fixed-point dot-product engine.
//                Each accepted beat multiplies LANES operand pairs (stage P),
//                sums them in an adder tree (stage S) and adds the sum to a
//                saturating accumulator. The beat flagged last produces one
//                N-bit saturated result with a sticky overflow flag, presented
//                on a valid/ready output. Last beat accepted in cycle t gives
//                out_valid in cycle t+3.
//  Config      : QMAC_ROUND_EN - per-lane round half up (see qmult_sat)
//  Ports       : clk, rst              clock, synchronous active-high reset
//                in_valid/in_ready     input beat handshake
//                in_last               beat closes the current vector
//                a_vec, b_vec          lane i operand at [i*N +: N]
//                out_valid/out_ready   result handshake
//                out_data              saturated Q-format result
//                out_ovr               any saturation within this vector
//  Revision    : 1.0 - initial release
// ============================================================================
module qmac_dot
    import qmac_pkg::*;
#(
    parameter int Q     = 10,
    parameter int N     = 32,
    parameter int LANES = 4,
    parameter int GUARD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [LANES*N-1:0] a_vec,
    input  logic [LANES*N-1:0] b_vec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_data,
    output logic               out_ovr
);

    localparam int c_SW = tree_width(N, LANES);
    localparam int c_AW = acc_width(N, LANES, GUARD);

    qmac_state_e r_state;

    logic                w_accept;
    logic [N-1:0]        w_lane_p [LANES];
    logic [LANES-1:0]    w_lane_ovr;

    logic [N-1:0]        r_p [LANES];
    logic                r_p_ovr;
    logic                r_p_valid;
    logic                r_p_last;

    logic signed [c_SW-1:0] w_tree_sum;
    logic [c_SW-1:0]     r_s;
    logic                r_s_ovr;
    logic                r_s_valid;
    logic                r_s_last;

    logic [c_AW-1:0]     r_acc;
    logic                r_ovr;
    logic [N-1:0]        r_out_data;
    logic                r_out_ovr;

    logic signed [c_SAT_W-1:0] w_sum_wide;
    sat_res_t            w_acc_sat;
    sat_res_t            w_out_sat;
    logic                w_unused_hi;

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_out_data;
    assign out_ovr   = r_out_ovr;
    assign w_accept  = in_valid & in_ready;

    // ---------------------------------------------------------------- lanes
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        qmult_sat #(
            .N (N),
            .Q (Q)
        ) u_mult (
            .i_a   (a_vec[gi*N +: N]),
            .i_b   (b_vec[gi*N +: N]),
            .o_p   (w_lane_p[gi]),
            .o_ovr (w_lane_ovr[gi])
        );
    end

    // -------------------------------------------------------------- stage P
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_p[i] <= '0;
            end
            r_p_ovr   <= 1'b0;
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
        end else begin
            r_p_valid <= w_accept;
            r_p_last  <= w_accept & in_last;
            if (w_accept) begin
                r_p     <= w_lane_p;
                r_p_ovr <= |w_lane_ovr;
            end
        end
    end

    // ------------------------------------------------------------ adder tree
    // Written as a linear sum; synthesis rebalances it into a tree. The
    // c_SW width holds the sum of LANES full-scale terms without loss.
    always_comb begin
        w_tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_tree_sum = w_tree_sum + c_SW'($signed(r_p[i]));
        end
    end

    // -------------------------------------------------------------- stage S
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s       <= '0;
            r_s_ovr   <= 1'b0;
            r_s_valid <= 1'b0;
            r_s_last  <= 1'b0;
        end else begin
            r_s_valid <= r_p_valid;
            r_s_last  <= r_p_last;
            if (r_p_valid) begin
                r_s     <= w_tree_sum;
                r_s_ovr <= r_p_ovr;
            end
        end
    end

    // ----------------------------------------------------------- accumulate
    // One exact wide sum feeds both clamps: to ACC width for ordinary beats
    // and straight to N bits for the closing beat.
    assign w_sum_wide  = c_SAT_W'($signed(r_acc)) + c_SAT_W'($signed(r_s));
    assign w_acc_sat   = sat_to_n(w_sum_wide, c_AW);
    assign w_out_sat   = sat_to_n(w_sum_wide, N);
    assign w_unused_hi = ^{w_acc_sat.val[c_SAT_W-1:c_AW], w_out_sat.val[c_SAT_W-1:N]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ACCUM;
            r_acc      <= '0;
            r_ovr      <= 1'b0;
            r_out_data <= '0;
            r_out_ovr  <= 1'b0;
        end else begin
            if (r_s_valid) begin
                if (r_s_last) begin
                    r_out_data <= w_out_sat.val[N-1:0];
                    r_out_ovr  <= r_ovr | r_s_ovr | w_out_sat.ovr;
                    r_acc      <= '0;
                    r_ovr      <= 1'b0;
                end else begin
                    r_acc <= w_acc_sat.val[c_AW-1:0];
                    r_ovr <= r_ovr | r_s_ovr | w_acc_sat.ovr;
                end
            end

            case (r_state)
                ST_ACCUM: if (w_accept && in_last)     r_state <= ST_DRAIN;
                ST_DRAIN: if (r_s_valid && r_s_last)   r_state <= ST_HOLD;
                ST_HOLD:  if (out_ready)               r_state <= ST_ACCUM;
                default:                               r_state <= ST_ACCUM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qmac_dot.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qmac_dot
//  Description : Self-checking bench for qmac_dot (Q=10, N=32, LANES=4).
//                Directed scenarios plus randomized vectors compared against
//                an arithmetic reference model.
//  Config      : QMAC_ROUND_EN - expected values follow round half up
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qmac_dot;

    localparam int Q     = 10;
    localparam int N     = 32;
    localparam int LANES = 4;
    localparam int GUARD = 8;
    localparam int c_TMO = 200;

    localparam longint c_MAXN    = 64'sd2147483647;
    localparam longint c_MINN    = -64'sd2147483648;
    localparam longint c_ACC_MAX = (longint'(1) <<< (N + 2 + GUARD - 1)) - 1;
    localparam longint c_ACC_MIN = -(longint'(1) <<< (N + 2 + GUARD - 1));

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic [LANES*N-1:0] a_vec;
    logic [LANES*N-1:0] b_vec;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       out_data;
    logic               out_ovr;

    int n_pass   = 0;
    int n_checks = 0;

    logic [LANES*N-1:0] m_a [8];
    logic [LANES*N-1:0] m_b [8];

    qmac_dot #(
        .Q     (Q),
        .N     (N),
        .LANES (LANES),
        .GUARD (GUARD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovr   (out_ovr)
    );

    always #5 clk = ~clk;

    function automatic logic [LANES*N-1:0] pack4(input logic [N-1:0] x0, input logic [N-1:0] x1,
                                                input logic [N-1:0] x2, input logic [N-1:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    // Reference: real-number dot product in Q format, lane clamp, exact
    // running sum with accumulator-range clamp, final clamp to N bits.
    function automatic void model_vec(input int nb, output logic [N-1:0] d, output logic o);
        longint acc, s, p, t, pa, pb;
        acc = 0;
        o   = 1'b0;
        d   = '0;
        for (int k = 0; k < nb; k++) begin
            s = 0;
            for (int i = 0; i < LANES; i++) begin
                pa = longint'($signed(m_a[k][i*N +: N]));
                pb = longint'($signed(m_b[k][i*N +: N]));
                p  = pa * pb;
`ifdef QMAC_ROUND_EN
                p = p + (longint'(1) <<< (Q - 1));
`endif
                p = p >>> Q;
                if (p > c_MAXN) begin p = c_MAXN; o = 1'b1; end
                else if (p < c_MINN) begin p = c_MINN; o = 1'b1; end
                s = s + p;
            end
            t = acc + s;
            if (k == nb - 1) begin
                if (t > c_MAXN) begin d = 32'h7FFFFFFF; o = 1'b1; end
                else if (t < c_MINN) begin d = 32'h80000000; o = 1'b1; end
                else d = t[N-1:0];
            end else begin
                if (t > c_ACC_MAX) begin acc = c_ACC_MAX; o = 1'b1; end
                else if (t < c_ACC_MIN) begin acc = c_ACC_MIN; o = 1'b1; end
                else acc = t;
            end
        end
    endfunction

    function automatic logic [N-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return N'(int'($urandom_range(0, 1 << 18)) - (1 << 17));
            1:       return N'($urandom);
            2:       return N'(int'($urandom_range(0, 4096)) - 2048);
            default: return N'(int'($urandom_range(0, 1 << 22)) - (1 << 21));
        endcase
    endfunction

    // Present one beat and hold it until accepted; 'waited' counts stall cycles.
    task automatic send_beat(input logic [LANES*N-1:0] a, input logic [LANES*N-1:0] b,
                             input logic last, output int waited);
        waited   = 0;
        a_vec    = a;
        b_vec    = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waited < c_TMO) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= c_TMO) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for out_valid; 'lat' counts edges after the last beat's acceptance.
    task automatic get_result(output logic [N-1:0] d, output logic o, output int lat);
        lat = 0;
        while (!out_valid && lat < c_TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= c_TMO) begin
            n_checks++;
            $display("FAIL result_timeout: out_valid 0 after %0d cycles, required 1", lat);
        end
        d = out_data;
        o = out_ovr;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        a_vec = '0; b_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b required 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %0h required 0", out_data); else n_pass++;
        n_checks++; if (out_ovr !== 1'b0) $display("FAIL reset_out_ovr: got %0b required 0", out_ovr); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b required 1", in_ready); else n_pass++;
    endtask

    task automatic test_single();
        logic [N-1:0] d; logic o; int lat; int w;
        send_beat(pack4(1024, 2048, 512, 0), pack4(1024, 1024, 2048, 5), 1'b1, w);
        get_result(d, o, lat);
        n_checks++; if (d !== 32'd4096) $display("FAIL single_data: got %0d required 4096", d); else n_pass++;
        n_checks++; if (o !== 1'b0) $display("FAIL single_ovr: got %0b required 0", o); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL single_latency: got t+%0d required t+3", lat + 1); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_multi_gap();
        logic [N-1:0] d; logic o; int lat; int w;
        send_beat(pack4(1024, 2048, 512, 0), pack4(1024, 1024, 2048, 5), 1'b0, w);
        send_beat(pack4(1024, 2048, 512, 0), pack4(1024, 1024, 2048, 5), 1'b0, w);
        @(posedge clk); #1;
        send_beat(pack4(1024, 2048, 512, 0), pack4(1024, 1024, 2048, 5), 1'b1, w);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL multi_ready_drain: got %0b required 0", in_ready); else n_pass++;
        get_result(d, o, lat);
        n_checks++; if (d !== 32'd12288) $display("FAIL multi_data: got %0d required 12288", d); else n_pass++;
        n_checks++; if (o !== 1'b0) $display("FAIL multi_ovr: got %0b required 0", o); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL multi_ready_hold: got %0b required 0", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL multi_ready_after: got %0b required 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL multi_valid_after: got %0b required 0", out_valid); else n_pass++;
    endtask

    task automatic test_saturate();
        logic [N-1:0] d; logic o; int lat; int w;
        send_beat(pack4(32'h100000, 32'h100000, 32'h100000, 32'h100000),
                  pack4(32'h100000, 32'h100000, 32'h100000, 32'h100000), 1'b1, w);
        get_result(d, o, lat);
        n_checks++; if (d !== 32'h7FFFFFFF) $display("FAIL sat_pos_data: got %0h required 7fffffff", d); else n_pass++;
        n_checks++; if (o !== 1'b1) $display("FAIL sat_pos_ovr: got %0b required 1", o); else n_pass++;
        @(posedge clk); #1;
        send_beat(pack4(32'hFFF00000, 32'hFFF00000, 32'hFFF00000, 32'hFFF00000),
                  pack4(32'h100000, 32'h100000, 32'h100000, 32'h100000), 1'b1, w);
        get_result(d, o, lat);
        n_checks++; if (d !== 32'h80000000) $display("FAIL sat_neg_data: got %0h required 80000000", d); else n_pass++;
        n_checks++; if (o !== 1'b1) $display("FAIL sat_neg_ovr: got %0b required 1", o); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_lane_ovr();
        logic [N-1:0] d; logic o; int lat; int w;
        send_beat(pack4(32'h40000000, 0, 0, 0), pack4(32'h40000000, 0, 0, 0), 1'b1, w);
        get_result(d, o, lat);
        n_checks++; if (d !== 32'h7FFFFFFF) $display("FAIL lane_ovr_data: got %0h required 7fffffff", d); else n_pass++;
        n_checks++; if (o !== 1'b1) $display("FAIL lane_ovr_flag: got %0b required 1", o); else n_pass++;
        @(posedge clk); #1;
        send_beat(pack4(1024, 2048, 512, 0), pack4(1024, 1024, 2048, 5), 1'b1, w);
        get_result(d, o, lat);
        n_checks++; if (d !== 32'd4096) $display("FAIL sticky_clear_data: got %0d required 4096", d); else n_pass++;
        n_checks++; if (o !== 1'b0) $display("FAIL sticky_clear_ovr: got %0b required 0", o); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] d; logic o; int lat; int w;
        out_ready = 1'b0;
        send_beat(pack4(1024, 2048, 512, 0), pack4(1024, 1024, 2048, 5), 1'b1, w);
        get_result(d, o, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++; if (out_data !== 32'd4096) $display("FAIL bp_data_stable: cycle %0d got %0d required 4096", c, out_data); else n_pass++;
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid_held: cycle %0d got %0b required 1", c, out_valid); else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: cycle %0d got %0b required 0", c, in_ready); else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after: got %0b required 1", in_ready); else n_pass++;
        send_beat(pack4(2048, 0, 0, 0), pack4(3072, 0, 0, 0), 1'b1, w);
        n_checks++; if (w !== 0) $display("FAIL bp_next_accept: stalled %0d cycles required 0", w); else n_pass++;
        get_result(d, o, lat);
        n_checks++; if (d !== 32'd6144) $display("FAIL bp_next_data: got %0d required 6144", d); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] d; logic o; int lat; int w;
        send_beat(pack4(1024, 2048, 512, 0), pack4(1024, 1024, 2048, 5), 1'b0, w);
        send_beat(pack4(1024, 2048, 512, 0), pack4(1024, 1024, 2048, 5), 1'b0, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_no_output: got %0b required 0", out_valid); else n_pass++;
        send_beat(pack4(1024, 2048, 512, 0), pack4(1024, 1024, 2048, 5), 1'b1, w);
        get_result(d, o, lat);
        n_checks++; if (d !== 32'd4096) $display("FAIL rstmid_data: got %0d required 4096", d); else n_pass++;
        n_checks++; if (o !== 1'b0) $display("FAIL rstmid_ovr: got %0b required 0", o); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_round();
        logic [N-1:0] d; logic o; int lat; int w; logic [N-1:0] exp_d;
`ifdef QMAC_ROUND_EN
        exp_d = 32'd1;
`else
        exp_d = 32'd0;
`endif
        send_beat(pack4(1, 0, 0, 0), pack4(512, 0, 0, 0), 1'b1, w);
        get_result(d, o, lat);
        n_checks++; if (d !== exp_d) $display("FAIL round_half: got %0d required %0d", d, exp_d); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [N-1:0] d; logic o; int lat; int w; int nb;
        logic [N-1:0] exp_d; logic exp_o;
        for (int v = 0; v < 25; v++) begin
            nb = $urandom_range(1, 5);
            for (int k = 0; k < nb; k++) begin
                m_a[k] = pack4(rand_op(), rand_op(), rand_op(), rand_op());
                m_b[k] = pack4(rand_op(), rand_op(), rand_op(), rand_op());
            end
            model_vec(nb, exp_d, exp_o);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                send_beat(m_a[k], m_b[k], (k == nb - 1), w);
            end
            get_result(d, o, lat);
            n_checks++; if (d !== exp_d) $display("FAIL rand_data: vec %0d got %0h required %0h", v, d, exp_d); else n_pass++;
            n_checks++; if (o !== exp_o) $display("FAIL rand_ovr: vec %0d got %0b required %0b", v, o, exp_o); else n_pass++;
            n_checks++; if (lat !== 2) $display("FAIL rand_latency: vec %0d got t+%0d required t+3", v, lat + 1); else n_pass++;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_gap();
        test_saturate();
        test_lane_ovr();
        test_backpressure();
        test_reset_mid();
        test_round();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
